// File: rtl/counter_pkg.sv
// counter_pkg: shared width, controller state enum and the hold encoding
// that freezes the 3-bit preset/clear counter at its current value.
package counter_pkg;
  localparam int CNT_W = 3;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  function automatic logic [2*CNT_W-1:0] hold_enc(input logic [CNT_W-1:0] q);
    return {q, ~q};
  endfunction
endpackage

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: loads a start value into the preset/clear counter, lets it
// free-run until a target state or step budget is hit, then reports the result.
module counter_seq_ctrl
  import counter_pkg::*;
#(
  parameter int STEP_W = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic              Abort,
  input  logic [CNT_W-1:0]  Load_val,
  input  logic [CNT_W-1:0]  Target,
  input  logic [STEP_W-1:0] Max_steps,
  input  logic [CNT_W-1:0]  Q_in,
  output logic [CNT_W-1:0]  Prs,
  output logic [CNT_W-1:0]  Clr,
  output logic              Busy,
  output logic              Done,
  output logic              Found,
  output logic [STEP_W-1:0] Steps
);
  state_t              r_state, w_nxt;
  logic [CNT_W-1:0]    r_load, r_target;
  logic [STEP_W-1:0]   r_max, r_cnt, r_steps;
  logic                r_found;
  logic                w_match, w_limit, w_stop;

  assign w_match = Q_in == r_target;
  assign w_limit = r_cnt == r_max;
  assign w_stop  = w_match || w_limit;
  assign Busy    = r_state == LOAD || r_state == RUN;
  assign Done    = r_state == DONE;
  assign Found   = r_found;
  assign Steps   = r_steps;

  always_comb begin
    w_nxt = r_state;
    {Prs, Clr} = hold_enc(Q_in);
    case (r_state)
      IDLE: w_nxt = Start ? LOAD : IDLE;
      LOAD: begin
        {Prs, Clr} = {r_load, ~r_load};
        w_nxt = Abort ? IDLE : RUN;
      end
      RUN: begin
        w_nxt = Abort ? IDLE : w_stop ? DONE : RUN;
        if (!Abort && !w_stop) {Prs, Clr} = '0;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state  <= IDLE;
      r_load   <= '0;
      r_target <= '0;
      r_max    <= '0;
      r_cnt    <= '0;
      r_found  <= 1'b0;
      r_steps  <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == IDLE && Start) begin
        r_load   <= Load_val;
        r_target <= Target;
        r_max    <= Max_steps;
        r_cnt    <= '0;
        r_found  <= 1'b0;
        r_steps  <= '0;
      end
      // an abort during LOAD reports zero steps, the same as an abort at RUN entry
      if (Busy && Abort) begin
        r_found <= 1'b0;
        r_steps <= r_cnt;
      end else if (r_state == RUN) begin
        if (w_stop) begin
          r_found <= w_match;
          r_steps <= r_cnt;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: drives the controller against a behavioural preset/clear
// counter and checks each run against a whole-run reference model.
module tb_counter_seq_ctrl;
  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Start = 1'b0;
  logic       Abort = 1'b0;
  logic [2:0] Load_val = '0;
  logic [2:0] Target = '0;
  logic [3:0] Max_steps = '0;
  logic [2:0] q = 3'b000;
  logic [2:0] Prs, Clr;
  logic       Busy, Done, Found;
  logic [3:0] Steps;
  int n_cmp = 0;
  int n_err = 0;

  counter_seq_ctrl #(.STEP_W(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Abort(Abort),
    .Load_val(Load_val), .Target(Target), .Max_steps(Max_steps), .Q_in(q),
    .Prs(Prs), .Clr(Clr), .Busy(Busy), .Done(Done), .Found(Found), .Steps(Steps)
  );

  always #5 Clk = ~Clk;

  function automatic logic [2:0] cnt_next(input logic [2:0] v);
    case (v)
      3'b000: return 3'b110;
      3'b110: return 3'b100;
      3'b100: return 3'b111;
      3'b111: return 3'b011;
      3'b011: return 3'b000;
      3'b101: return 3'b010;
      3'b010: return 3'b111;
      default: return 3'b100;
    endcase
  endfunction

  always @(posedge Clk)
    q <= (Prs != 3'b000 || Clr != 3'b000) ? ((q | Prs) & ~Clr) : cnt_next(q);

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hold(input string tag);
    logic [2:0] nq;
    nq = ~q;
    chk({tag, "_prs"}, Prs, q);
    chk({tag, "_clr"}, Clr, nq);
  endtask

  task automatic ref_run(input logic [2:0] l, t, input logic [3:0] m,
                         output logic f, output logic [3:0] s, output logic [2:0] fq);
    int k;
    fq = l;
    k = 0;
    while (fq != t && k < m) begin
      fq = cnt_next(fq);
      k++;
    end
    f = fq == t;
    s = 4'(k);
  endtask

  task automatic do_run(input string tag, input logic [2:0] l, t, input logic [3:0] m);
    logic f;
    logic [3:0] s;
    logic [2:0] fq, nl;
    int n;
    ref_run(l, t, m, f, s, fq);
    nl = ~l;
    Load_val = l; Target = t; Max_steps = m; Start = 1'b1;
    step;
    Start = 1'b0;
    chk({tag, "_busy"}, Busy, 1);
    chk({tag, "_load_prs"}, Prs, l);
    chk({tag, "_load_clr"}, Clr, nl);
    n = 0;
    do begin
      step;
      n++;
    end while (!Done && n < 40);
    chk({tag, "_latency"}, n, s + 2);
    chk({tag, "_found"}, Found, f);
    chk({tag, "_steps"}, Steps, s);
    chk({tag, "_q"}, q, fq);
    chk_hold({tag, "_done"});
    step;
    chk({tag, "_done_pulse"}, Done, 0);
    chk({tag, "_idle_busy"}, Busy, 0);
    repeat (5) step;
    chk({tag, "_q_frozen"}, q, fq);
    chk({tag, "_found_kept"}, Found, f);
    chk({tag, "_steps_kept"}, Steps, s);
  endtask

  initial begin
    logic [2:0] qh;
    repeat (2) step;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_found", Found, 0);
    chk("rst_steps", Steps, 0);
    chk_hold("rst_hold");
    Rst_n = 1'b1;
    step;

    do_run("t1", 3'b000, 3'b111, 4'd10);
    do_run("t2", 3'b101, 3'b000, 4'd15);
    do_run("t3", 3'b001, 3'b001, 4'd0);
    do_run("t4", 3'b000, 3'b101, 4'd7);
    do_run("t5", 3'b110, 3'b011, 4'd0);

    Load_val = 3'b000; Target = 3'b101; Max_steps = 4'd15; Start = 1'b1;
    step;
    Start = 1'b0;
    step;
    Start = 1'b1; Load_val = 3'b111;
    step;
    Start = 1'b0;
    step;
    chk("ab_busy_run", Busy, 1);
    Abort = 1'b1;
    step;
    Abort = 1'b0;
    chk("ab_busy", Busy, 0);
    chk("ab_found", Found, 0);
    chk("ab_steps", Steps, 2);
    chk("ab_q", q, 3'b100);
    chk_hold("ab_hold");
    repeat (4) begin
      step;
      chk("ab_no_done", Done, 0);
    end
    chk("ab_q_frozen", q, 3'b100);

    Load_val = 3'b000; Target = 3'b101; Max_steps = 4'd15; Start = 1'b1;
    step;
    Start = 1'b0;
    repeat (2) step;
    Rst_n = 1'b0;
    step;
    chk("mr_busy", Busy, 0);
    chk("mr_done", Done, 0);
    chk("mr_found", Found, 0);
    chk("mr_steps", Steps, 0);
    chk_hold("mr_hold");
    qh = q;
    repeat (2) step;
    chk("mr_q_frozen", q, qh);
    Rst_n = 1'b1;
    step;
    do_run("mr_fresh", 3'b100, 3'b000, 4'd9);

    for (int i = 0; i < 12; i++)
      do_run($sformatf("rnd%0d", i), 3'($urandom_range(7)), 3'($urandom_range(7)),
             4'($urandom_range(15)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
